// File: rtl/alu.sv
// Registered 32-bit ALU with zero and signed-overflow flags, one-cycle latency.
// Define ALU_OVERFLOW_EN to build the overflow register; otherwise overflow is tied low.
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  ALU_operation,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] res,
    output logic        zero,
    output logic        overflow
);

    localparam int DATA_W = 32;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    // Two's-complement overflow: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    logic signed [DATA_W-1:0] sum_s;
    logic signed [DATA_W-1:0] diff_s;
    logic                     diff_ovf;
    logic                     slt_bit;
    logic        [DATA_W-1:0] res_nxt;

    assign a_s    = A;
    assign b_s    = B;
    assign sum_s  = a_s + b_s;
    assign diff_s = a_s - b_s;

    // Kept in every build: SLT depends on it regardless of the flag output.
    assign diff_ovf = sub_ovf(a_s[DATA_W-1], b_s[DATA_W-1], diff_s[DATA_W-1]);
    assign slt_bit  = diff_s[DATA_W-1] ^ diff_ovf;

    always_comb begin
        res_nxt = '0;
        unique case (ALU_operation)
            OP_AND:  res_nxt = A & B;
            OP_OR:   res_nxt = A | B;
            OP_ADD:  res_nxt = sum_s;
            OP_XOR:  res_nxt = A ^ B;
            OP_NOR:  res_nxt = ~(A | B);
            OP_SRL:  res_nxt = A >> B[4:0];
            OP_SUB:  res_nxt = diff_s;
            OP_SLT:  res_nxt = {{(DATA_W-1){1'b0}}, slt_bit};
            default: res_nxt = '0;
        endcase
    end

    // ---- stage p1: output registers ----
    logic [DATA_W-1:0] res_p1;
    logic              zero_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_p1  <= '0;
            zero_p1 <= 1'b1;
        end else begin
            res_p1  <= res_nxt;
            zero_p1 <= (res_nxt == '0);
        end
    end

    assign res  = res_p1;
    assign zero = zero_p1;

`ifdef ALU_OVERFLOW_EN
    logic ovf_nxt;
    logic ovf_p1;

    always_comb begin
        ovf_nxt = 1'b0;
        if (ALU_operation == OP_ADD)
            ovf_nxt = add_ovf(a_s[DATA_W-1], b_s[DATA_W-1], sum_s[DATA_W-1]);
        else if (ALU_operation == OP_SUB)
            ovf_nxt = diff_ovf;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_p1 <= 1'b0;
        else
            ovf_p1 <= ovf_nxt;
    end

    assign overflow = ovf_p1;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset/hold sequences,
// and randomized operations checked against an arithmetic reference model.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [2:0]  ALU_operation;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] res;
    logic        zero;
    logic        overflow;

    int errors = 0;
    int checks = 0;

`ifdef ALU_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    alu dut (
        .clk(clk),
        .rst(rst),
        .ALU_operation(ALU_operation),
        .A(A),
        .B(B),
        .res(res),
        .zero(zero),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        ov;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs[NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model from the operation definitions using wide signed arithmetic.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic ov);
        longint sa, sb, wide;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ov = 1'b0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin wide = sa + sb; r = wide[31:0]; ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
            3'd3: r = a ^ b;
            3'd4: r = ~(a | b);
            3'd5: r = a >> (b % 32);
            3'd6: begin wide = sa - sb; r = wide[31:0]; ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
            default: r = (sa < sb) ? 32'd1 : 32'd0;
        endcase
    endtask

    task automatic apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        ALU_operation = op;
        A = a;
        B = b;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic [31:0] r, input logic z, input logic ov);
        chk({name, ".res"}, res, r);
        chk({name, ".zero"}, {31'b0, zero}, {31'b0, z});
        chk({name, ".ovf"}, {31'b0, overflow}, {31'b0, ov & OVF_EN});
    endtask

    initial begin
        logic [31:0] er;
        logic        eov;
        logic [31:0] held;

        vecs[0]  = '{3'b111, 32'd6,          32'd4,          32'd0,          1'b1, 1'b0};
        vecs[1]  = '{3'b111, 32'd4,          32'd6,          32'd1,          1'b0, 1'b0};
        vecs[2]  = '{3'b111, 32'hFFFFFFF0,   32'd0,          32'd1,          1'b0, 1'b0};
        vecs[3]  = '{3'b111, 32'd64,         32'd576,        32'd1,          1'b0, 1'b0};
        vecs[4]  = '{3'b111, 32'd576,        32'd64,         32'd0,          1'b1, 1'b0};
        vecs[5]  = '{3'b111, 32'd0,          32'd416,        32'd1,          1'b0, 1'b0};
        vecs[6]  = '{3'b111, 32'd32,         32'd416,        32'd1,          1'b0, 1'b0};
        vecs[7]  = '{3'b010, 32'h7FFFFFFF,   32'd1,          32'h80000000,   1'b0, 1'b1};
        vecs[8]  = '{3'b110, 32'h12345678,   32'h12345678,   32'd0,          1'b1, 1'b0};
        vecs[9]  = '{3'b110, 32'h80000000,   32'd1,          32'h7FFFFFFF,   1'b0, 1'b1};
        vecs[10] = '{3'b000, 32'hF0F0F0F0,   32'h0FF00FF0,   32'h00F000F0,   1'b0, 1'b0};
        vecs[11] = '{3'b001, 32'hF0F0F0F0,   32'h0FF00FF0,   32'hFFF0FFF0,   1'b0, 1'b0};
        vecs[12] = '{3'b011, 32'hF0F0F0F0,   32'h0FF00FF0,   32'hFF00FF00,   1'b0, 1'b0};
        vecs[13] = '{3'b100, 32'hF0F0F0F0,   32'h0FF00FF0,   32'h000F000F,   1'b0, 1'b0};
        vecs[14] = '{3'b101, 32'h80000000,   32'h00000024,   32'h08000000,   1'b0, 1'b0};
        vecs[15] = '{3'b111, 32'h80000000,   32'd1,          32'd1,          1'b0, 1'b0};
        vecs[16] = '{3'b111, 32'h7FFFFFFF,   32'hFFFFFFFF,   32'd0,          1'b1, 1'b0};
        vecs[17] = '{3'b010, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b1, 1'b0};
        vecs[18] = '{3'b010, 32'h80000000,   32'h80000000,   32'd0,          1'b1, 1'b1};
        vecs[19] = '{3'b110, 32'h7FFFFFFF,   32'hFFFFFFFF,   32'h80000000,   1'b0, 1'b1};

        // Asynchronous reset with no clock edge in between.
        rst = 1'b0;
        ALU_operation = 3'b111;
        A = 32'd6;
        B = 32'd4;
        #2;
        rst = 1'b1;
        #1;
        chk_out("reset_async", 32'd0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk_out("reset_held", 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_out("reset_release", 32'd0, 1'b1, 1'b0);

        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b);
            chk_out($sformatf("vec%0d", i), vecs[i].res, vecs[i].z, vecs[i].ov);
        end

        // Outputs hold while inputs change between edges.
        apply(3'b010, 32'd100, 32'd23);
        held = res;
        ALU_operation = 3'b100;
        A = 32'd0;
        B = 32'd0;
        #3;
        chk("hold_between_edges", res, 32'd123);
        chk("hold_value_stable", res, held);

        // Mid-operation reset discards the pending result.
        @(negedge clk);
        ALU_operation = 3'b001;
        A = 32'h00FF0000;
        B = 32'h0000FF00;
        #1;
        rst = 1'b1;
        #1;
        chk_out("midop_reset", 32'd0, 1'b1, 1'b0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_out("post_reset_edge", 32'h00FFFF00, 1'b0, 1'b0);

        // Randomized operations with corner-biased operands.
        for (int i = 0; i < 300; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: a = 32'h80000000;
                1: a = 32'h7FFFFFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: b = a;
                1: b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            model(op, a, b, er, eov);
            apply(op, a, b);
            chk_out($sformatf("rand%0d_op%0d", i, op), er, (er == 32'd0), eov);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
